// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the core's control blocks.
//   cru_state_t : state encoding of the call/return unit FSM
//   WIDTH       : PC, return-address and stack data width
//   STACK_DEPTH : number of entries the return-address stack can hold safely.
//                 The stack uses a 5-bit pointer, so a 32nd push would wrap it.
package cpu_pkg;

    localparam int WIDTH       = 16;
    localparam int STACK_DEPTH = 31;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PUSH   = 3'd1,
        POP    = 3'd2,
        LOAD   = 3'd3,
        REJECT = 3'd4
    } cru_state_t;

endpackage : cpu_pkg

// File: rtl/call_return_unit.sv
// call_return_unit: initiator side of the hardware return-address stack.
// Turns CALL/RET requests into single-cycle push/pop strobes and hands the
// resulting next PC to fetch. The stack has no full/empty flags, so occupancy
// is tracked here and requests that would overflow or underflow are rejected.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   call_req, ret_req   requests, held by the requester until ack
//   pc_in, call_target  PC of the CALL and its destination
//   err_clr             clears the sticky error flags (a coincident set wins)
//   stack_dataout       stack read data, valid while stack_pop is high
//   stack_push/pop      one-cycle strobes to the stack
//   stack_datain        return address to push
//   pc_load, pc_next    one-cycle load strobe and next PC for fetch
//   ack                 one-cycle completion pulse (accepted or rejected)
//   busy                FSM is not in IDLE
//   depth               current number of live stack entries
//   overflow_err        sticky: CALL rejected with the stack full
//   underflow_err       sticky: RET rejected with the stack empty
//
// Handshake: a request is sampled only in IDLE. The unit answers with exactly
// one ack pulse; the requester drops its request in the cycle after ack. A
// request still high once the FSM is back in IDLE counts as a new request.
// All outputs are registered.
module call_return_unit #(
    parameter int WIDTH      = cpu_pkg::WIDTH,
    parameter int DEPTH      = cpu_pkg::STACK_DEPTH,
    parameter int DEPTH_W    = 6,
    parameter int RET_OFFSET = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               call_req,
    input  logic               ret_req,
    input  logic [WIDTH-1:0]   pc_in,
    input  logic [WIDTH-1:0]   call_target,
    input  logic               err_clr,
    input  logic [WIDTH-1:0]   stack_dataout,
    output logic               stack_push,
    output logic               stack_pop,
    output logic [WIDTH-1:0]   stack_datain,
    output logic               pc_load,
    output logic [WIDTH-1:0]   pc_next,
    output logic               ack,
    output logic               busy,
    output logic [DEPTH_W-1:0] depth,
    output logic               overflow_err,
    output logic               underflow_err
);

    import cpu_pkg::cru_state_t;
    import cpu_pkg::IDLE;
    import cpu_pkg::PUSH;
    import cpu_pkg::POP;
    import cpu_pkg::LOAD;
    import cpu_pkg::REJECT;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

    cru_state_t         state, state_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic               push_d, pop_d, pc_load_d, ack_d, busy_d;
    logic               ovf_d, unf_d;
    logic [WIDTH-1:0]   datain_d, pc_next_d;
    logic [DEPTH_W-1:0] depth_d;

    // State register plus registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            target_q      <= '0;
            stack_push    <= 1'b0;
            stack_pop     <= 1'b0;
            stack_datain  <= '0;
            pc_load       <= 1'b0;
            pc_next       <= '0;
            ack           <= 1'b0;
            busy          <= 1'b0;
            depth         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            state         <= state_d;
            target_q      <= target_d;
            stack_push    <= push_d;
            stack_pop     <= pop_d;
            stack_datain  <= datain_d;
            pc_load       <= pc_load_d;
            pc_next       <= pc_next_d;
            ack           <= ack_d;
            busy          <= busy_d;
            depth         <= depth_d;
            overflow_err  <= ovf_d;
            underflow_err <= unf_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        target_d  = target_q;
        push_d    = 1'b0;
        pop_d     = 1'b0;
        datain_d  = stack_datain;
        pc_load_d = 1'b0;
        pc_next_d = pc_next;
        ack_d     = 1'b0;
        depth_d   = depth;
        // Clear first so that an error raised below in the same cycle wins.
        ovf_d     = err_clr ? 1'b0 : overflow_err;
        unf_d     = err_clr ? 1'b0 : underflow_err;

        case (state)
            IDLE: begin
                if (call_req) begin
                    if (depth < DEPTH_MAX) begin
                        push_d   = 1'b1;
                        datain_d = pc_in + WIDTH'(RET_OFFSET);
                        target_d = call_target;
                        state_d  = PUSH;
                    end else begin
                        ovf_d   = 1'b1;
                        ack_d   = 1'b1;
                        state_d = REJECT;
                    end
                end else if (ret_req) begin
                    if (depth != '0) begin
                        pop_d   = 1'b1;
                        state_d = POP;
                    end else begin
                        unf_d   = 1'b1;
                        ack_d   = 1'b1;
                        state_d = REJECT;
                    end
                end
            end
            PUSH: begin
                // The stack writes on this edge; the entry is now live.
                depth_d   = depth + DEPTH_W'(1);
                pc_next_d = target_q;
                pc_load_d = 1'b1;
                ack_d     = 1'b1;
                state_d   = LOAD;
            end
            POP: begin
                // stack_dataout is valid only while stack_pop is high.
                depth_d   = depth - DEPTH_W'(1);
                pc_next_d = stack_dataout;
                pc_load_d = 1'b1;
                ack_d     = 1'b1;
                state_d   = LOAD;
            end
            LOAD:    state_d = IDLE;
            REJECT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule : call_return_unit
